// File: rtl/xbar_slave_arbiter.sv
// -----------------------------------------------------------------------------
// xbar_slave_arbiter
//
// Purpose
//   Round-robin arbiter that sits in front of one crossbar slave port. It
//   collects master requests already decoded to this slave and grants exactly
//   one master at a time. The grant is held until the granted master's
//   transaction is acknowledged by the slave, or until that master drops its
//   request. grant[i] drives connect_approved_from_crossbar of master i.
//
//   Every release is followed by one IDLE cycle with no grant. Grants are
//   therefore spaced at least two cycles apart, even when requests are held
//   continuously. The scan for the next winner starts one past the previous
//   winner, so a master that keeps req high after its ack competes again with
//   the lowest priority.
//
// Optional feature
//   ARB_TIMEOUT_EN (define to enable): a watchdog counts BUSY cycles that end
//   without a release. When the count reaches TIMEOUT_CYCLES the grant is
//   revoked at the next edge and timeout_err pulses high for one cycle. With
//   the macro undefined there is no counter, timeout_err is constant 0, and a
//   grant is held indefinitely.
//
// Parameters
//   N_MASTERS       number of requesting masters (>= 2)
//   TIMEOUT_CYCLES  watchdog limit in cycles (ARB_TIMEOUT_EN only)
//
// Ports
//   clk          in   clock, all state changes on the rising edge
//   rst_n        in   asynchronous reset, active low
//   req          in   per-master request, decoded to this slave
//   ack_slave    in   acknowledge returned by this slave
//   grant        out  one-hot connect approval per master (registered)
//   grant_valid  out  a grant is currently held (registered OR of grant)
//   grant_idx    out  index of the granted master, 0 when no grant is held
//   timeout_err  out  one-cycle pulse on a watchdog revoke
// -----------------------------------------------------------------------------
module xbar_slave_arbiter #(
  parameter int N_MASTERS      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_MASTERS-1:0]         req,
  input  logic                         ack_slave,
  output logic [N_MASTERS-1:0]         grant,
  output logic                         grant_valid,
  output logic [$clog2(N_MASTERS)-1:0] grant_idx,
  output logic                         timeout_err
);

  localparam int IDX_W = $clog2(N_MASTERS);

  // After reset the scan starts one past the last master, so master 0 wins first.
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_MASTERS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] last_winner;
  logic [IDX_W-1:0] pick_idx;
  logic             release_now;

  // Round-robin choice: first set request scanning last+1, last+2, ... with
  // wrap-around. The result is only used when at least one request is set.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [N_MASTERS-1:0] r,
    input logic [IDX_W-1:0]     last
  );
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand_idx;
    logic             found;
    int               cand;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      cand     = (int'(last) + k) % N_MASTERS;
      cand_idx = IDX_W'(cand);
      if (!found && r[cand_idx]) begin
        pick  = cand_idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [N_MASTERS-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_MASTERS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Candidate selection, consumed only in IDLE
  always_comb begin
    pick_idx = rr_pick(req, last_winner);
  end

  // Release covers both a completed transaction (ack while still requesting)
  // and an abandoned one (granted master dropped req). An ack arriving in the
  // same cycle as the request drop is simply a release.
  assign release_now = ack_slave | ~req[grant_idx];

`ifdef ARB_TIMEOUT_EN
  localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] busy_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  // Arbitration FSM: all outputs registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      last_winner <= LAST_RST;
`ifdef ARB_TIMEOUT_EN
      busy_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // ack_slave is deliberately not looked at here.
          if (|req) begin
            grant       <= to_onehot(pick_idx);
            grant_valid <= 1'b1;
            grant_idx   <= pick_idx;
            state       <= BUSY;
`ifdef ARB_TIMEOUT_EN
            busy_cnt    <= '0;
`endif
          end
        end

        BUSY: begin
          // Requests from other masters are ignored while a grant is held.
          if (release_now) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            last_winner <= grant_idx;
            state       <= IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (busy_cnt == CNT_LIMIT) begin
            // Watchdog revoke: same bookkeeping as a normal release, so the
            // offending master drops to lowest priority and the bubble follows.
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            last_winner <= grant_idx;
            state       <= IDLE;
            timeout_err <= 1'b1;
          end else begin
            busy_cnt    <= busy_cnt + 1'b1;
          end
`endif
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
